cc_muxx_pipe: RTL

Parametrised, registered N-to-1 data-path multiplexer with a valid/ready handshake, and the successor to the fixed 38-input combinational bus mux. It adds a configurable channel count and width, and registers the selected word through a two-entry skid stage so Ready_Out is a flop. It also adds an auto-scan mode that sweeps all channels in order, and a sticky out-of-range selection flag. It sits between the register-bank/special-register read buses and downstream datapath consumers (ALU operand latch, debug readout).

---
 rtl/cc_muxp_pkg.sv | 15 +
 rtl/cc_skid_buffer.sv | 53 +++++
 rtl/cc_muxx_pipe.sv | 117 +++++++++++
 3 files changed

// File: rtl/cc_muxp_pkg.sv
// Shared constants and helpers for the registered channel multiplexer.
package cc_muxp_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Payload carried through the skid stage: {word, channel index, scan-last flag}.
    function automatic int unsigned payloadWidth(input int unsigned dataWidth,
                                                 input int unsigned selWidth);
        return dataWidth + selWidth + 1;
    endfunction

    localparam int unsigned PAYLOAD_WIDTH_DEFAULT = payloadWidth(32, 6);

endpackage

// File: rtl/cc_skid_buffer.sv
// Two-entry valid/ready skid stage: output register plus one skid register,
// so the upstream ready is driven straight from a flop.
module cc_skid_buffer #(
    parameter int unsigned PAYLOAD_WIDTH = 39
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     inValid_i,
    output logic                     inReady_o,
    input  logic [PAYLOAD_WIDTH-1:0] inData_i,
    output logic                     outValid_o,
    input  logic                     outReady_i,
    output logic [PAYLOAD_WIDTH-1:0] outData_o
);

    logic                     outValidQ;
    logic [PAYLOAD_WIDTH-1:0] outDataQ;
    logic                     skidValidQ;
    logic [PAYLOAD_WIDTH-1:0] skidDataQ;
    logic                     accept;
    logic                     outFree;

    assign inReady_o  = ~skidValidQ;
    assign accept     = inValid_i & ~skidValidQ;
    assign outFree    = ~outValidQ | outReady_i;
    assign outValid_o = outValidQ;
    assign outData_o  = outDataQ;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            outValidQ  <= 1'b0;
            outDataQ   <= '0;
            skidValidQ <= 1'b0;
            skidDataQ  <= '0;
        end else if (outFree) begin
            // Skid content is always older than anything arriving now.
            if (skidValidQ) begin
                outValidQ  <= 1'b1;
                outDataQ   <= skidDataQ;
                skidValidQ <= 1'b0;
            end else if (accept) begin
                outValidQ <= 1'b1;
                outDataQ  <= inData_i;
            end else begin
                outValidQ <= 1'b0;
            end
        end else if (accept) begin
            skidValidQ <= 1'b1;
            skidDataQ  <= inData_i;
        end
    end

endmodule

// File: rtl/cc_muxx_pipe.sv
// Registered N-to-1 channel multiplexer with direct/auto-scan selection,
// sticky out-of-range flag and a valid/ready skid output stage.
module cc_muxx_pipe
    import cc_muxp_pkg::*;
#(
    parameter int unsigned DATAWIDTH_BUS           = 32,
    parameter int unsigned NUM_CHANNELS            = 38,
    parameter int unsigned DATAWIDTH_MUX_SELECTION = 6
) (
    input  logic                                  CC_MUXP_CLOCK_50,
    input  logic                                  CC_MUXP_RESET_InHigh,
    input  logic [NUM_CHANNELS*DATAWIDTH_BUS-1:0] CC_MUXP_DataBUS_In,
    input  logic [DATAWIDTH_MUX_SELECTION-1:0]    CC_MUXP_Selection_In,
    input  logic                                  CC_MUXP_Mode_In,
    input  logic                                  CC_MUXP_Valid_In,
    output logic                                  CC_MUXP_Ready_Out,
    output logic [DATAWIDTH_BUS-1:0]              CC_MUXP_DataBUS_Out,
    output logic [DATAWIDTH_MUX_SELECTION-1:0]    CC_MUXP_Channel_Out,
    output logic                                  CC_MUXP_ScanLast_Out,
    output logic                                  CC_MUXP_Valid_Out,
    input  logic                                  CC_MUXP_Ready_In,
    output logic                                  CC_MUXP_SelError_Out,
    input  logic                                  CC_MUXP_ErrClear_In
);

    localparam int unsigned PayloadW = payloadWidth(DATAWIDTH_BUS, DATAWIDTH_MUX_SELECTION);
    localparam int unsigned SelW     = DATAWIDTH_MUX_SELECTION;

    localparam logic [SelW:0]   NumChannels = (SelW + 1)'(NUM_CHANNELS);
    localparam logic [SelW-1:0] LastIdx     = SelW'(NUM_CHANNELS - 1);

    logic                     accept;
    logic                     scanMode;
    logic                     selInRange;
    logic [SelW-1:0]          idx;
    logic [DATAWIDTH_BUS-1:0] selWord;
    logic                     scanLast;
    logic [SelW-1:0]          scanQ, scanD;
    logic                     errQ, errD;
    logic [PayloadW-1:0]      inPayload;
    logic [PayloadW-1:0]      outPayload;

    assign accept     = CC_MUXP_Valid_In & CC_MUXP_Ready_Out;
    assign scanMode   = (CC_MUXP_Mode_In == MODE_SCAN);
    assign selInRange = ({1'b0, CC_MUXP_Selection_In} < NumChannels);

    always_comb begin
        idx      = '0;
        scanLast = 1'b0;
        if (scanMode) begin
            idx      = scanQ;
            scanLast = (scanQ == LastIdx);
        end else if (selInRange) begin
            idx = CC_MUXP_Selection_In;
        end
    end

    // Compare-and-select keeps the index width independent of the bus width.
    always_comb begin
        selWord = '0;
        for (int k = 0; k < int'(NUM_CHANNELS); k++) begin
            if (idx == SelW'(k)) begin
                selWord = CC_MUXP_DataBUS_In[k*DATAWIDTH_BUS +: DATAWIDTH_BUS];
            end
        end
    end

    always_comb begin
        scanD = scanQ;
        if (!scanMode) begin
            scanD = '0;
        end else if (accept) begin
            scanD = (scanQ == LastIdx) ? '0 : scanQ + 1'b1;
        end
    end

    // A new out-of-range accept wins over a simultaneous clear.
    always_comb begin
        errD = errQ;
        if (accept && !scanMode && !selInRange) begin
            errD = 1'b1;
        end else if (CC_MUXP_ErrClear_In) begin
            errD = 1'b0;
        end
    end

    always_ff @(posedge CC_MUXP_CLOCK_50) begin
        if (CC_MUXP_RESET_InHigh) begin
            scanQ <= '0;
            errQ  <= 1'b0;
        end else begin
            scanQ <= scanD;
            errQ  <= errD;
        end
    end

    assign inPayload = {selWord, idx, scanLast};

    cc_skid_buffer #(
        .PAYLOAD_WIDTH(PayloadW)
    ) u_skid (
        .clk_i     (CC_MUXP_CLOCK_50),
        .rst_i     (CC_MUXP_RESET_InHigh),
        .inValid_i (CC_MUXP_Valid_In),
        .inReady_o (CC_MUXP_Ready_Out),
        .inData_i  (inPayload),
        .outValid_o(CC_MUXP_Valid_Out),
        .outReady_i(CC_MUXP_Ready_In),
        .outData_o (outPayload)
    );

    assign CC_MUXP_DataBUS_Out  = outPayload[PayloadW-1 -: DATAWIDTH_BUS];
    assign CC_MUXP_Channel_Out  = outPayload[SelW:1];
    assign CC_MUXP_ScanLast_Out = outPayload[0];
    assign CC_MUXP_SelError_Out = errQ;

endmodule
